// File: rtl/led_ring_pkg.sv
// Shared definitions for the LED ring animator: mode encodings, FSM states,
// the reset-time palette and the channel scaling helper.
package led_ring_pkg;

   localparam logic [1:0] MODE_HOLD = 2'd0;
   localparam logic [1:0] MODE_UP   = 2'd1;
   localparam logic [1:0] MODE_DOWN = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam int unsigned PALETTE_LEN = 7;

   // Lit-channel masks {red, green, blue}, in palette order.
   localparam logic [2:0] PAL_RED    = 3'b100;
   localparam logic [2:0] PAL_GREEN  = 3'b010;
   localparam logic [2:0] PAL_BLUE   = 3'b001;
   localparam logic [2:0] PAL_YELLOW = 3'b110;
   localparam logic [2:0] PAL_PURPLE = 3'b101;
   localparam logic [2:0] PAL_CYAN   = 3'b011;
   localparam logic [2:0] PAL_WHITE  = 3'b111;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_LATCH = 2'd1,
      ST_WAIT  = 2'd2
   } ring_state_t;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   function automatic rgb_t palette_rgb(input int unsigned idx, input logic [7:0] level);
      logic [2:0] lit;
      rgb_t       c;
      case (idx % PALETTE_LEN)
         0:       lit = PAL_RED;
         1:       lit = PAL_GREEN;
         2:       lit = PAL_BLUE;
         3:       lit = PAL_YELLOW;
         4:       lit = PAL_PURPLE;
         5:       lit = PAL_CYAN;
         default: lit = PAL_WHITE;
      endcase
      c.red   = lit[2] ? level : 8'h00;
      c.green = lit[1] ? level : 8'h00;
      c.blue  = lit[0] ? level : 8'h00;
      return c;
   endfunction

   // (c * (b + 1)) >> 8; the product never exceeds 16 bits.
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
      logic [16:0] p;
      p = 17'(c) * (17'(b) + 17'd1);
      return p[15:8];
   endfunction

endpackage

// File: rtl/led_ring_timer.sv
// WAIT-phase counter: a start pulse arms it, done is high on the last of
// TICK_CYCLES counted cycles (TICK_CYCLES >= 2).
module led_ring_timer #(
   parameter int unsigned TICK_CYCLES = 4194304
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic start,
   output logic done
);

   localparam int unsigned CNT_W = $clog2(TICK_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic             active_q;

   // done is registered one count early so it lines up with the final cycle.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         count_q  <= '0;
         active_q <= 1'b0;
         done     <= 1'b0;
      end else if (start) begin
         count_q  <= '0;
         active_q <= 1'b1;
         done     <= 1'b0;
      end else if (active_q) begin
         count_q <= count_q + CNT_W'(1);
         done    <= (count_q == CNT_W'(TICK_CYCLES - 2));
         if (done) begin
            active_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/led_ring_animator.sv
// Frame-buffered LED ring animator feeding a ws2812b_controller load port.
// Optional build macro LED_RING_SCALE_EN enables global brightness scaling.
module led_ring_animator
   import led_ring_pkg::*;
#(
   parameter int unsigned NB_LEDS     = 12,
   parameter logic [7:0]  LEVEL       = 8'h20,
   parameter int unsigned TICK_CYCLES = 4194304
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [1:0]  mode,
   input  logic [7:0]  brightness,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [23:0] wr_rgb,
   output logic        wr_ready,
   output logic [7:0]  address,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        load,
   output logic        latch_n
);

   localparam int unsigned IDX_W = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;

   ring_state_t state_q;
   logic [7:0]  index_q;
   logic        last_wait_q;
   logic        timer_start_c;
   logic        timer_done;
   rgb_t        buf_q     [NB_LEDS];
   rgb_t        buf_nxt_c [NB_LEDS];
   rgb_t        rd_c;
   rgb_t        out_c;

   assign timer_start_c = (state_q == ST_LATCH);

   led_ring_timer #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_timer (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .start    (timer_start_c),
      .done     (timer_done)
   );

   // Buffer updates happen only while wr_ready is high; rotation on the last
   // WAIT cycle goes first so a coincident write overrides its target.
   always_comb begin
      buf_nxt_c = buf_q;
      if (last_wait_q) begin
         for (int unsigned i = 0; i < NB_LEDS; i++) begin
            case (mode)
               MODE_UP:   buf_nxt_c[IDX_W'(i)] = buf_q[IDX_W'((i == 0) ? NB_LEDS - 1 : i - 1)];
               MODE_DOWN: buf_nxt_c[IDX_W'(i)] = buf_q[IDX_W'((i == NB_LEDS - 1) ? 0 : i + 1)];
               default:   buf_nxt_c[IDX_W'(i)] = buf_q[IDX_W'(i)];
            endcase
         end
      end
      if (wr_en && wr_ready) begin
         for (int unsigned i = 0; i < NB_LEDS; i++) begin
            if (wr_addr == 8'(i)) begin
               buf_nxt_c[IDX_W'(i)] = rgb_t'(wr_rgb);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < NB_LEDS; i++) begin
            buf_q[IDX_W'(i)] <= palette_rgb(i, LEVEL);
         end
      end else begin
         buf_q <= buf_nxt_c;
      end
   end

   // Read from the post-update view so frame start sees the rotated buffer.
   always_comb begin
      rd_c = '0;
      for (int unsigned i = 0; i < NB_LEDS; i++) begin
         if (index_q == 8'(i)) begin
            rd_c = buf_nxt_c[IDX_W'(i)];
         end
      end
   end

   always_comb begin
`ifdef LED_RING_SCALE_EN
      out_c.red   = scale_chan(rd_c.red,   brightness);
      out_c.green = scale_chan(rd_c.green, brightness);
      out_c.blue  = scale_chan(rd_c.blue,  brightness);
`else
      out_c = rd_c;
`endif
   end

`ifndef LED_RING_SCALE_EN
   logic unused_brightness_c;
   assign unused_brightness_c = ^brightness;
`endif

   // Sequencer; outputs show the phase the state held in the previous cycle.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_LOAD;
         index_q     <= 8'd0;
         last_wait_q <= 1'b0;
         load        <= 1'b0;
         latch_n     <= 1'b1;
         address     <= 8'd0;
         red         <= 8'd0;
         green       <= 8'd0;
         blue        <= 8'd0;
         wr_ready    <= 1'b0;
      end else begin
         load        <= 1'b0;
         latch_n     <= 1'b1;
         address     <= 8'd0;
         red         <= 8'd0;
         green       <= 8'd0;
         blue        <= 8'd0;
         wr_ready    <= 1'b0;
         last_wait_q <= 1'b0;
         case (state_q)
            ST_LOAD: begin
               load    <= 1'b1;
               address <= index_q;
               red     <= out_c.red;
               green   <= out_c.green;
               blue    <= out_c.blue;
               if (index_q == 8'(NB_LEDS - 1)) begin
                  index_q <= 8'd0;
                  state_q <= ST_LATCH;
               end else begin
                  index_q <= index_q + 8'd1;
               end
            end
            ST_LATCH: begin
               latch_n <= 1'b0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               wr_ready <= 1'b1;
               if (timer_done) begin
                  last_wait_q <= 1'b1;
                  state_q     <= ST_LOAD;
               end
            end
            default: begin
               state_q <= ST_LOAD;
               index_q <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/led_ring_animator.md
LED_RING_ANIMATOR -- requirements
Module: led_ring_animator

Interface
REQ-001 SHALL have parameter NB_LEDS, default 12, meaning number of addressable LEDs on the ring; legal range 1..255.
REQ-002 SHALL have parameter LEVEL, default 8'h20, meaning channel intensity used for the reset-time palette.
REQ-003 SHALL have parameter TICK_CYCLES, default 4194304, meaning WAIT duration in clock cycles; legal minimum 2.
REQ-004 SHALL have port CLOCK_50, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port mode, input, 2 bits: 0 hold, 1 rotate up, 2 rotate down, 3 reserved (treated as hold).
REQ-007 SHALL have port brightness, input, 8 bits, meaning global scale (used only under REQ-027).
REQ-008 SHALL have port wr_en, input, 1 bit, meaning frame-buffer write request.
REQ-009 SHALL have port wr_addr, input, 8 bits, meaning target LED index.
REQ-010 SHALL have port wr_rgb, input, 24 bits, meaning {red, green, blue} to write.
REQ-011 SHALL have port wr_ready, output, 1 bit, meaning a write is accepted this cycle.
REQ-012 SHALL have ports address (8 bits), red (8), green (8), blue (8), load (1) and latch_n (1) as outputs, meaning the ws2812b_controller load interface.

Function
REQ-013 SHALL hold a frame buffer of NB_LEDS 24-bit entries.
REQ-014 SHALL run FSM LOAD -> LATCH -> WAIT -> LOAD.
- LOAD: NB_LEDS cycles, index 0..NB_LEDS-1; load=1, address=index, {red,green,blue}=buffer[index].
- LATCH: exactly 1 cycle; latch_n=0, load=0.
- WAIT: exactly TICK_CYCLES cycles; load=0, latch_n=1.
REQ-015 SHALL drive address=0, red/green/blue=0 whenever load=0; latch_n=1 outside LATCH.
REQ-016 SHALL give a frame period of exactly NB_LEDS+1+TICK_CYCLES cycles.
REQ-017 SHALL sample mode on the last WAIT cycle and update the buffer on that edge.
- Rotate up: buffer[i] <= buffer[i-1], buffer[0] <= buffer[NB_LEDS-1].
- Rotate down: buffer[i] <= buffer[i+1], buffer[NB_LEDS-1] <= buffer[0].
- Hold/reserved: unchanged.
- NB_LEDS=1: no change in any mode.
REQ-018 SHALL assert wr_ready only in WAIT; a write occurs when wr_en and wr_ready are both high.
REQ-019 SHALL ignore writes with wr_addr >= NB_LEDS; wr_ready is unaffected.
REQ-020 SHALL, when a write coincides with the rotation edge, apply the rotation first, with the write then overriding the target entry.
REQ-021 SHALL never alter buffer contents during LOAD or LATCH, so every frame sent is coherent.

Reset
REQ-022 SHALL, when RESET_N=0, immediately force state=LOAD, index=0, wait counter=0, load=0, latch_n=1, address=0, red/green/blue=0, wr_ready=0.
REQ-023 SHALL initialise buffer[i] to palette[i mod 7]: red, green, blue, yellow, purple, cyan, white, with each lit channel at LEVEL.
REQ-024 SHALL start LOAD index 0 on the first edge after release; load=1 from that cycle.
REQ-025 SHALL, on reset mid-frame, abandon the frame with no LATCH pulse.

Configuration
REQ-026 SHALL, without LED_RING_SCALE_EN, output buffer values unmodified and ignore brightness.
REQ-027 SHALL, with LED_RING_SCALE_EN, output each channel as (c*(brightness+1))>>8, with LOAD timing unchanged.

Structure
REQ-028 SHALL place mode encodings, the palette constants and the scale function in shared package led_ring_pkg.
REQ-029 SHALL use sub-module led_ring_timer, a TICK_CYCLES wait counter with start/done.

Verification
REQ-030 SHALL cover reset release with defaults: 12 load cycles with address 0..11, where address 0 gives red=0x20, green=0, blue=0 and address 6 gives 0x20/0x20/0x20; then latch_n low 1 cycle; next load after TICK_CYCLES.
REQ-031 SHALL cover mode=1 for two frames: frame 2 address 1 shows red 0x20, and address 0 shows the former buffer[11].
REQ-032 SHALL cover mode=2 for one tick: address 11 shows red 0x20.
REQ-033 SHALL cover wr_en with addr 3 and rgb 0x0A0B0C on the last WAIT cycle with mode=1: next frame address 3 = 0x0A0B0C; the write during LOAD is ignored and wr_ready=0.
REQ-034 SHALL cover RESET_N low at LOAD index 5: outputs go zero immediately, there is no latch, and the palette is restored.
REQ-035 SHALL cover LED_RING_SCALE_EN with brightness 0x7F: a red 0x20 entry outputs 0x10.
